core_seq_ctrl: RTL

- Multi-cycle sequencer for the RV32 npc core: steps the datapath through fetch, decode, execute, memory and writeback.
- Handshakes with instruction and data memory using req/ready.
- Detects ebreak, illegal opcodes and a stalled pipeline, then freezes the core in HALT with a halt code.
- Keeps cycle and retired-instruction counters for the simulation harness.

---
 rtl/core_ctrl_pkg.sv | 60 ++++++
 rtl/retire_watchdog.sv | 43 ++++
 rtl/core_seq_ctrl.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/core_ctrl_pkg.sv
// Shared definitions for the RV32 npc core sequencer.
//   state_e      : sequencer states
//   OP_*         : RV32I major opcodes (ir[6:0])
//   EBREAK       : full encoding of ebreak, used as the "good" halt trigger
//   HC_*         : halt_code values reported on halt
//   is_legal_op  : opcode belongs to the supported RV32I subset
//   is_mem_op    : opcode needs a data-memory access (LOAD/STORE)
//   writes_rf    : opcode writes a destination register in WB
package core_ctrl_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StDecode,
        StExec,
        StMem,
        StWb,
        StHalt
    } state_e;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    localparam logic [31:0] EBREAK = 32'h00100073;

    localparam logic [1:0] HC_NONE    = 2'b00;
    localparam logic [1:0] HC_GOOD    = 2'b01;
    localparam logic [1:0] HC_ILLEGAL = 2'b10;
    localparam logic [1:0] HC_WDOG    = 2'b11;

    function automatic logic is_legal_op(input logic [6:0] op);
        logic legal;
        legal = 1'b0;
        case (op)
            OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_IMM, OP_REG,
            OP_LOAD, OP_STORE, OP_BRANCH, OP_FENCE, OP_SYSTEM: legal = 1'b1;
            default: legal = 1'b0;
        endcase
        return legal;
    endfunction

    function automatic logic is_mem_op(input logic [6:0] op);
        return (op == OP_LOAD) || (op == OP_STORE);
    endfunction

    function automatic logic writes_rf(input logic [6:0] op);
        return !((op == OP_STORE) || (op == OP_BRANCH) || (op == OP_FENCE) ||
                 (op == OP_SYSTEM));
    endfunction

endpackage

// File: rtl/retire_watchdog.sv
// Counts active cycles since the last retirement and flags a timeout on the
// cycle in which the count would reach WDOG_LIMIT.
//   clk     in  core clock
//   rst     in  asynchronous active-low reset
//   clear   in  restart the count (start from idle, or a retirement)
//   enable  in  core is in an active state this cycle
//   timeout out this cycle is the WDOG_LIMIT-th active cycle without a retirement
module retire_watchdog #(
    parameter int unsigned WDOG_LIMIT = 1000000
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic timeout
);

    localparam int unsigned CW = $clog2(WDOG_LIMIT + 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Fires combinationally so the sequencer leaves its active state on the
    // same edge at which the count reaches the limit.
    assign timeout = enable && !clear && (cnt_q == CW'(WDOG_LIMIT - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/core_seq_ctrl.sv
// Multi-cycle sequencer for the RV32 npc core. Walks the datapath through
// FETCH, DECODE, EXEC or MEM, and WB; halts on ebreak, illegal opcode or a
// retirement watchdog timeout.
//   clk, rst              clock, asynchronous active-low reset
//   start                 pulse that leaves IDLE
//   pc                    current PC from the datapath
//   imem_req/ready/rdata  instruction fetch handshake
//   ir                    latched instruction
//   dmem_req/we/ready     data access handshake (we=1 for stores)
//   pc_we, rf_we          one-cycle write strobes, only in WB
//   halt, halt_code, halt_pc  sticky halt status
//   cycle_cnt, instret_cnt    active-cycle and retired-instruction counters
module core_seq_ctrl
    import core_ctrl_pkg::*;
#(
    parameter int unsigned WDOG_LIMIT = 1000000,
    parameter int unsigned CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [31:0]      pc,
    output logic             imem_req,
    input  logic             imem_ready,
    input  logic [31:0]      imem_rdata,
    output logic [31:0]      ir,
    output logic             dmem_req,
    output logic             dmem_we,
    input  logic             dmem_ready,
    output logic             pc_we,
    output logic             rf_we,
    output logic             halt,
    output logic [1:0]       halt_code,
    output logic [31:0]      halt_pc,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instret_cnt
);

    state_e           state_q, state_d;
    logic [31:0]      ir_q, ir_d;
    logic [1:0]       halt_code_q, halt_code_d;
    logic [31:0]      halt_pc_q, halt_pc_d;
    logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;
    logic [CNT_W-1:0] instret_cnt_q, instret_cnt_d;

    logic [6:0] opcode;
    logic       active;
    logic       wdog_clear;
    logic       wdog_timeout;

    assign opcode = ir_q[6:0];
    assign active = (state_q == StFetch) || (state_q == StDecode) || (state_q == StExec) ||
                    (state_q == StMem) || (state_q == StWb);

    // Restart on leaving IDLE and on every retirement.
    assign wdog_clear = ((state_q == StIdle) && start) || (state_q == StWb);

    retire_watchdog #(
        .WDOG_LIMIT (WDOG_LIMIT)
    ) u_retire_watchdog (
        .clk     (clk),
        .rst     (rst),
        .clear   (wdog_clear),
        .enable  (active),
        .timeout (wdog_timeout)
    );

    always_comb begin
        state_d     = state_q;
        ir_d        = ir_q;
        halt_code_d = halt_code_q;
        halt_pc_d   = halt_pc_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StFetch;
                end
            end
            StFetch: begin
                if (imem_ready) begin
                    ir_d    = imem_rdata;
                    state_d = StDecode;
                end
            end
            StDecode: begin
                if (ir_q == EBREAK) begin
                    state_d     = StHalt;
                    halt_code_d = HC_GOOD;
                    halt_pc_d   = pc;
                end else if (!is_legal_op(opcode)) begin
                    state_d     = StHalt;
                    halt_code_d = HC_ILLEGAL;
                    halt_pc_d   = pc;
                end else if (is_mem_op(opcode)) begin
                    state_d = StMem;
                end else begin
                    state_d = StExec;
                end
            end
            StExec: begin
                state_d = StWb;
            end
            StMem: begin
                if (dmem_ready) begin
                    state_d = StWb;
                end
            end
            StWb: begin
                state_d = StFetch;
            end
            StHalt: begin
                state_d = StHalt;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Watchdog overrides any same-cycle transition, abandoning a pending
        // handshake; an instruction arriving on that cycle is not latched.
        if (wdog_timeout) begin
            state_d     = StHalt;
            ir_d        = ir_q;
            halt_code_d = HC_WDOG;
            halt_pc_d   = pc;
        end
    end

    always_comb begin
        cycle_cnt_d   = cycle_cnt_q;
        instret_cnt_d = instret_cnt_q;
        if (active) begin
            cycle_cnt_d = cycle_cnt_q + CNT_W'(1);
        end
        if (state_q == StWb) begin
            instret_cnt_d = instret_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= StIdle;
            ir_q          <= '0;
            halt_code_q   <= HC_NONE;
            halt_pc_q     <= '0;
            cycle_cnt_q   <= '0;
            instret_cnt_q <= '0;
        end else begin
            state_q       <= state_d;
            ir_q          <= ir_d;
            halt_code_q   <= halt_code_d;
            halt_pc_q     <= halt_pc_d;
            cycle_cnt_q   <= cycle_cnt_d;
            instret_cnt_q <= instret_cnt_d;
        end
    end

    // Requests and strobes decode from the registered state only, so they are
    // glitch-free and cleared the moment reset forces IDLE.
    assign imem_req    = (state_q == StFetch);
    assign dmem_req    = (state_q == StMem);
    assign dmem_we     = (state_q == StMem) && (opcode == OP_STORE);
    assign pc_we       = (state_q == StWb);
    assign rf_we       = (state_q == StWb) && writes_rf(opcode);
    assign halt        = (state_q == StHalt);
    assign ir          = ir_q;
    assign halt_code   = halt_code_q;
    assign halt_pc     = halt_pc_q;
    assign cycle_cnt   = cycle_cnt_q;
    assign instret_cnt = instret_cnt_q;

endmodule
